mdu_sequencer: RTL
==================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle multiply/divide unit with its HI/LO register pair, sitting in the EX stage.
//  Sequences MULT/MULTU/DIV/DIVU over a fixed latency, performs single-cycle MTHI/MTLO,
//  and returns HI or LO for MFHI/MFLO.
//  Takes start/read_sel from the EX-stage MDU hazard controller and returns busy to it.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD family when enabled); >=1
//  DIV_CYCLES   10  busy cycles for DIV/DIVU; >=1
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  start     in   1   launch op in opcode/func this cycle (only meaningful when busy==0)
//  opcode    in   6   IR_E[31:26] of the launching instruction
//  func      in   6   IR_E[5:0] of the launching instruction
//  rs_val    in   32  forwarded rs operand
//  rt_val    in   32  forwarded rt operand
//  flush     in   1   kill: cancels a same-cycle start and aborts any op in flight
//  read_sel  in   2   01=HI, 10=LO, else 0; combinational read
//  busy      out  1   multi-cycle op in flight
//  rd_data   out  32  HI/LO/0 per read_sel, combinational from current registers
//  hi, lo    out  32  architectural HI/LO (debug/trace)
// BEHAVIOUR
//  Reset: hi=lo=0, busy=0, state IDLE, counter 0; rd_data follows read_sel (0 after reset).
//  Ops (opcode==0): MTHI 010001, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010,
//   DIVU 011011. Any other code with start=1 is ignored (no state change).
//  FSM IDLE/BUSY. IDLE & start & !flush:
//   MTHI/MTLO: hi/lo <= rs_val at that edge; stay IDLE; busy stays 0.
//   MULT*/DIV*: latch rs/rt and op, cnt <= N (MULT_CYCLES or DIV_CYCLES), -> BUSY.
//  BUSY: cnt decrements each edge; at the edge where cnt==1, commit result to hi/lo and
//   return to IDLE. busy=1 exactly N cycles; new hi/lo visible the cycle busy falls.
//  start while BUSY: ignored (controller guarantees none); simulation assertion fires.
//  Arithmetic on latched operands:
//   MULT signed 32x32->64, MULTU unsigned; {hi,lo} <= product.
//   DIV signed: lo=quotient truncated toward zero, hi=remainder with dividend sign;
//   0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU unsigned.
//   Divisor 0 (DIV/DIVU): full latency still taken, hi/lo left unchanged.
//  flush: with start in same cycle -> start dropped. In BUSY -> IDLE next edge, cnt=0,
//   hi/lo unchanged, busy 0 the next cycle. flush and cnt==1 on the same edge -> flush wins.
//  read_sel during BUSY returns the old value (controller stalls MF* while busy).
//  rst_n low mid-op: immediate abort to reset values.
// CONFIGURATION
//  MDU_MADD_EN defined: opcode 011100 (SPECIAL2) with func 000000 MADD, 000001 MADDU,
//   000100 MSUB, 000101 MSUBU accepted. Latency MULT_CYCLES.
//   {hi,lo} <= {hi,lo} +/- product, using the hi/lo values present at commit, mod 2^64.
//  Not defined: SPECIAL2 codes are ignored like any unknown code; no accumulate logic built.
// STRUCTURE
//  Shared package mips_defs_pkg: FUNC_MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU,
//   OP_SPECIAL, OP_SPECIAL2, FUNC_MADD/MADDU/MSUB/MSUBU, READ_HI=2'b01, READ_LO=2'b10,
//   and the MDU state enum.
//  One sub-module, mdu_arith: combinational mult/div/accumulate on latched operands
//   producing {hi_next, lo_next, div_by_zero}.
//  The top level holds the FSM, counter, operand latches and HI/LO.
// TESTING
//  MULT rs=0xFFFFFFFE, rt=3 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
//  DIV rs=-7, rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIVU rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
//  DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  MTLO rs=0x1234 -> lo=0x1234 next cycle, busy never set; read_sel=10 -> rd_data=0x1234.
//  DIV launched, flush on cycle 4 -> busy 0 next cycle, hi/lo unchanged.
//  start+flush same cycle -> no busy.
//  rst_n pulsed low mid-MULT -> busy=0, hi=lo=0 immediately.
//  With MDU_MADD_EN: hi:lo=0:5, MADD 2*3 -> lo=11.
//  MSUBU 1*6 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF wrap.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS opcode/function encodings, HI/LO read selects and MDU enums.
package mips_defs_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    localparam logic [5:0] FUNC_MADD  = 6'b000000;
    localparam logic [5:0] FUNC_MADDU = 6'b000001;
    localparam logic [5:0] FUNC_MSUB  = 6'b000100;
    localparam logic [5:0] FUNC_MSUBU = 6'b000101;

    localparam logic [1:0] READ_HI = 2'b01;
    localparam logic [1:0] READ_LO = 2'b10;

    typedef enum logic {
        MDU_IDLE,
        MDU_BUSY
    } mdu_state_e;

    typedef enum logic [2:0] {
        MDU_MULT,
        MDU_MULTU,
        MDU_DIV,
        MDU_DIVU,
        MDU_MADD,
        MDU_MADDU,
        MDU_MSUB,
        MDU_MSUBU
    } mdu_op_e;

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage MDU hazard controller <-> MDU sequencer bundle.
interface mdu_sequencer_if;
    logic        start;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic [1:0]  read_sel;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, opcode, func, rs_val, rt_val, flush, read_sel,
        input  busy, rd_data, hi, lo
    );

    modport slave (
        input  start, opcode, func, rs_val, rt_val, flush, read_sel,
        output busy, rd_data, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational mult/div (and accumulate when MDU_MADD_EN is defined) on the
// latched operands; the sequencer samples the result on its final busy cycle.
module mdu_arith
    import mips_defs_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_MADD_EN
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
`endif
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div_by_zero
);

    logic [63:0] prod_s, prod_u, res;
    logic        sgn_div;
    logic [31:0] dvd, dvs, q_mag, r_mag, quo, rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case:
    // magnitude 0x80000000 / 1 gives the architecturally expected 0x80000000.
    assign sgn_div     = (op == MDU_DIV);
    assign div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
    assign dvd   = (sgn_div && a[31]) ? (~a + 32'd1) : a;
    assign dvs   = (b == 32'd0) ? 32'd1 : ((sgn_div && b[31]) ? (~b + 32'd1) : b);
    assign q_mag = dvd / dvs;
    assign r_mag = dvd % dvs;
    assign quo   = (sgn_div && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = (sgn_div && a[31]) ? (~r_mag + 32'd1) : r_mag;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_cur, lo_cur};
`endif

    always_comb begin
        res = '0;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV,
            MDU_DIVU:  res = {rem, quo};
`ifdef MDU_MADD_EN
            MDU_MADD:  res = acc + prod_s;
            MDU_MADDU: res = acc + prod_u;
            MDU_MSUB:  res = acc - prod_s;
            MDU_MSUBU: res = acc - prod_u;
`endif
            default:   res = '0;
        endcase
        hi_next = res[63:32];
        lo_next = res[31:0];
    end

endmodule

// File: rtl/mdu_sequencer.sv
// EX-stage multi-cycle multiply/divide unit with HI/LO.
// Define MDU_MADD_EN to accept the SPECIAL2 MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_sequencer
    import mips_defs_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst_n,
    mdu_sequencer_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_op_e          op_q, op_d, dec_op;
    logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic             dec_mthi, dec_mtlo, dec_launch, dec_div;
    logic [31:0]      ar_hi, ar_lo;
    logic             ar_dbz;

    always_comb begin
        dec_mthi   = 1'b0;
        dec_mtlo   = 1'b0;
        dec_launch = 1'b0;
        dec_div    = 1'b0;
        dec_op     = MDU_MULT;
        if (bus.opcode == OP_SPECIAL) begin
            case (bus.func)
                FUNC_MTHI:  dec_mthi = 1'b1;
                FUNC_MTLO:  dec_mtlo = 1'b1;
                FUNC_MULT:  begin dec_launch = 1'b1; dec_op = MDU_MULT;  end
                FUNC_MULTU: begin dec_launch = 1'b1; dec_op = MDU_MULTU; end
                FUNC_DIV:   begin dec_launch = 1'b1; dec_op = MDU_DIV;   dec_div = 1'b1; end
                FUNC_DIVU:  begin dec_launch = 1'b1; dec_op = MDU_DIVU;  dec_div = 1'b1; end
                default:    ;
            endcase
        end
`ifdef MDU_MADD_EN
        else if (bus.opcode == OP_SPECIAL2) begin
            case (bus.func)
                FUNC_MADD:  begin dec_launch = 1'b1; dec_op = MDU_MADD;  end
                FUNC_MADDU: begin dec_launch = 1'b1; dec_op = MDU_MADDU; end
                FUNC_MSUB:  begin dec_launch = 1'b1; dec_op = MDU_MSUB;  end
                FUNC_MSUBU: begin dec_launch = 1'b1; dec_op = MDU_MSUBU; end
                default:    ;
            endcase
        end
`endif
    end

    mdu_arith u_arith (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
`ifdef MDU_MADD_EN
        .hi_cur      (hi_q),
        .lo_cur      (lo_q),
`endif
        .hi_next     (ar_hi),
        .lo_next     (ar_lo),
        .div_by_zero (ar_dbz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (dec_mthi) hi_d = bus.rs_val;
                    if (dec_mtlo) lo_d = bus.rs_val;
                    if (dec_launch) begin
                        op_d    = dec_op;
                        a_d     = bus.rs_val;
                        b_d     = bus.rt_val;
                        cnt_d   = dec_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d = MDU_BUSY;
                    end
                end
            end
            MDU_BUSY: begin
                // Flush beats the final-cycle commit.
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    if (!ar_dbz) begin
                        hi_d = ar_hi;
                        lo_d = ar_lo;
                    end
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == MDU_BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.rd_data = (bus.read_sel == READ_HI) ? hi_q :
                         (bus.read_sel == READ_LO) ? lo_q : 32'd0;

    // The hazard controller must never launch while an op is in flight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            start_while_busy: assert (!(bus.start && (state_q == MDU_BUSY)));
        end
    end

endmodule
